uart_rx_cfg: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver in the serial-control path. Consumes the shared oversampling tick (s_tick) from the baud generator. Recovers frames with configurable data width, parity mode and stop-bit count. Reports data together with parity and framing error status, for the command decoder that drives the SDRAM/VGA control registers.

---
 rtl/uart_rx_cfg.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (data width, parity, stop bits) on a shared oversampling tick.
// Optional macro UART_RX_MAJORITY_VOTE_EN selects 2-of-3 majority sampling at each decision tick.
module uart_rx_cfg #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            data_in,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] data_out,
  output logic            parity_err,
  output logic            frame_err,
  output logic            rx_busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DBIT);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);
  localparam logic          SB_LAST  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [BW-1:0]   bit_reg, bit_next;
  logic            sb_reg, sb_next;
  logic [DBIT-1:0] shift_reg, shift_next;
  logic            pe_reg, pe_next;
  logic            fe_reg, fe_next;
  logic            rx_meta_reg, rx_s;
  logic            sample;
  logic            complete;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= data_in;
      rx_s        <= rx_meta_reg;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The two previous tick samples plus the live one form the vote window ending at the decision tick.
  logic [1:0] hist_reg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      hist_reg <= 2'b11;
    else if (s_tick)
      hist_reg <= {hist_reg[0], rx_s};
  end
  assign sample = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rx_s) | (hist_reg[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      sb_reg    <= 1'b0;
      shift_reg <= '0;
      pe_reg    <= 1'b0;
      fe_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      sb_reg    <= sb_next;
      shift_reg <= shift_next;
      pe_reg    <= pe_next;
      fe_reg    <= fe_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    sb_next    = sb_reg;
    shift_next = shift_reg;
    pe_next    = pe_reg;
    fe_next    = fe_reg;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (cnt_reg == CNT_MID) begin
            if (!sample) begin
              state_next = DATA;
              cnt_next   = '0;
              bit_next   = '0;
              sb_next    = 1'b0;
              pe_next    = 1'b0;
              fe_next    = 1'b0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (cnt_reg == CNT_END) begin
            cnt_next   = '0;
            shift_next = {sample, shift_reg[DBIT-1:1]};
            if (bit_reg == BIT_LAST)
              state_next = (PARITY != 0) ? PAR : STOP;
            else
              bit_next = bit_reg + 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      PAR: begin
        if (s_tick) begin
          if (cnt_reg == CNT_END) begin
            cnt_next   = '0;
            pe_next    = ((^shift_reg) ^ sample) != (PARITY == 2);
            state_next = STOP;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (cnt_reg == CNT_END) begin
            cnt_next = '0;
            fe_next  = fe_reg | ~sample;
            if (sb_reg == SB_LAST)
              state_next = IDLE;
            else
              sb_next = sb_reg + 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_busy  = (state_reg != IDLE);
    complete = (state_reg == STOP) && s_tick && (cnt_reg == CNT_END) && (sb_reg == SB_LAST);
  end

  // The final stop sample is folded straight into frame_err so all results land on one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_done_tick <= 1'b0;
      data_out     <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= complete;
      if (complete) begin
        data_out   <= shift_reg;
        parity_err <= pe_reg;
        frame_err  <= fe_reg | ~sample;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised bench for uart_rx_cfg: three configurations, frame-level expected-result queue.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  localparam int TP = 8;  // clocks per s_tick
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam bit VOTE = 1'b1;
`else
  localparam bit VOTE = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] inst;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       s_tick = 1'b0;
  logic [2:0] line = 3'b111;
  logic [2:0] rst_n = 3'b111;
  logic [2:0] done, pe, fe, busy;
  logic [7:0] dout_a, dout_b;
  logic [6:0] dout_c;

  int cfg_dbit [3] = '{8, 8, 7};
  int cfg_os   [3] = '{16, 16, 8};
  int cfg_par  [3] = '{0, 1, 2};
  int cfg_ns   [3] = '{1, 1, 2};

  exp_t expq [$];
  exp_t last [3];
  logic [2:0] prev_busy = 3'b000;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DBIT(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset_n(rst_n[0]), .data_in(line[0]), .s_tick(s_tick),
    .rx_done_tick(done[0]), .data_out(dout_a), .parity_err(pe[0]), .frame_err(fe[0]), .rx_busy(busy[0]));
  uart_rx_cfg #(.DBIT(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .reset_n(rst_n[1]), .data_in(line[1]), .s_tick(s_tick),
    .rx_done_tick(done[1]), .data_out(dout_b), .parity_err(pe[1]), .frame_err(fe[1]), .rx_busy(busy[1]));
  uart_rx_cfg #(.DBIT(7), .OVERSAMPLE(8), .PARITY(2), .STOP_BITS(2)) dut_c (
    .clk(clk), .reset_n(rst_n[2]), .data_in(line[2]), .s_tick(s_tick),
    .rx_done_tick(done[2]), .data_out(dout_c), .parity_err(pe[2]), .frame_err(fe[2]), .rx_busy(busy[2]));

  function automatic logic [8:0] dout_of(int i);
    case (i)
      0:       return {1'b0, dout_a};
      1:       return {1'b0, dout_b};
      default: return {2'b00, dout_c};
    endcase
  endfunction

  task automatic check(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      s_tick = ((k % TP) == 0);
    end
  end

  // Per-cycle comparison against the frame queue and the last delivered result.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n[i]) begin
        check("reset_outputs", i, 32'({done[i], dout_of(i), pe[i], fe[i], busy[i]}), 32'd0);
      end else if (done[i]) begin
        if (expq.size() == 0 || int'(expq[0].inst) != i) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done dut%0d: got pulse, required none at %0t", i, $time);
        end else begin
          e = expq.pop_front();
          $display("dut%0d frame data=%0h pe=%0b fe=%0b (exp %0h %0b %0b)",
                   i, dout_of(i), pe[i], fe[i], e.data, e.pe, e.fe);
          check("data_out", i, 32'(dout_of(i)), 32'(e.data));
          check("parity_err", i, 32'(pe[i]), 32'(e.pe));
          check("frame_err", i, 32'(fe[i]), 32'(e.fe));
          last[i] = e;
        end
        check("busy_with_pulse", i, 32'(busy[i]), 32'd0);
        check("busy_before_pulse", i, 32'(prev_busy[i]), 32'd1);
      end else begin
        check("hold_data", i, 32'(dout_of(i)), 32'(last[i].data));
        check("hold_pe", i, 32'(pe[i]), 32'(last[i].pe));
        check("hold_fe", i, 32'(fe[i]), 32'(last[i].fe));
      end
      prev_busy[i] = busy[i];
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (s_tick !== 1'b1);
    #1;
  endtask

  task automatic drive_seg(int i, logic v, int n);
    line[i] = v;
    repeat (n) wait_tick();
  endtask

  // One frame on line i; stop_low[s] forces stop bit s low (the last one only up to just past its midpoint).
  task automatic send_frame(int i, logic [8:0] data_in_w, bit flip, bit [1:0] stop_low, bit glitch0);
    int os, nb, par, ns;
    logic [8:0] data;
    logic pbit;
    exp_t e;
    os = cfg_os[i];
    nb = cfg_dbit[i];
    par = cfg_par[i];
    ns = cfg_ns[i];
    data = data_in_w & 9'((32'd1 << nb) - 1);
    if (glitch0) data[0] = 1'b0;
    e.inst = 2'(i);
    e.data = (glitch0 && !VOTE) ? (data | 9'd1) : data;
    e.pe = (par != 0) && flip;
    e.fe = stop_low[0] | ((ns == 2) && stop_low[1]);
    expq.push_back(e);
    drive_seg(i, 1'b0, os);
    for (int b = 0; b < nb; b++) begin
      if (glitch0 && b == 0) begin
        drive_seg(i, 1'b0, os / 2 - 1);
        drive_seg(i, 1'b1, 1);
        drive_seg(i, 1'b0, os / 2);
      end else begin
        drive_seg(i, data[b], os);
      end
    end
    if (par != 0) begin
      pbit = (^data) ^ (par == 2) ^ flip;
      drive_seg(i, pbit, os);
    end
    for (int s = 0; s < ns; s++) begin
      if (stop_low[s]) begin
        if (s == ns - 1) begin
          drive_seg(i, 1'b0, os / 2 + 2);
          drive_seg(i, 1'b1, os / 2 - 2);
        end else begin
          drive_seg(i, 1'b0, os);
        end
      end else begin
        drive_seg(i, 1'b1, os);
      end
    end
    check("frame_delivered", i, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int inst, gap;
    bit flip;
    bit [1:0] sl;
    for (int i = 0; i < 3; i++) last[i] = '0;
    #2 rst_n = 3'b000;
    repeat (4) @(posedge clk);
    #1 rst_n = 3'b111;
    for (int i = 0; i < 3; i++) begin
      check("reset_done", i, 32'(done[i]), 32'd0);
      check("reset_data", i, 32'(dout_of(i)), 32'd0);
      check("reset_busy", i, 32'(busy[i]), 32'd0);
    end
    wait_tick();

    // 8N1 basic frame
    send_frame(0, 9'h55, 1'b0, 2'b00, 1'b0);
    drive_seg(0, 1'b1, 4);
    check("pin_55_data", 0, 32'(dout_a), 32'h55);
    check("pin_55_fe", 0, 32'(fe[0]), 32'd0);

    // short start pulse must be rejected
    drive_seg(0, 1'b0, 3);
    drive_seg(0, 1'b1, 40);
    check("start_glitch_busy", 0, 32'(busy[0]), 32'd0);
    check("start_glitch_data", 0, 32'(dout_a), 32'h55);

    // framing error then a clean frame
    send_frame(0, 9'h3C, 1'b0, 2'b01, 1'b0);
    drive_seg(0, 1'b1, 20);
    check("pin_3c_data", 0, 32'(dout_a), 32'h3C);
    check("pin_3c_fe", 0, 32'(fe[0]), 32'd1);
    send_frame(0, 9'h01, 1'b0, 2'b00, 1'b0);
    check("pin_01_fe", 0, 32'(fe[0]), 32'd0);

    // single-tick high glitch at the bit-0 decision point
    send_frame(0, 9'h00, 1'b0, 2'b00, 1'b1);
    check("pin_glitch_data", 0, 32'(dout_a), VOTE ? 32'h00 : 32'h01);

    // even parity: wrong then right
    send_frame(1, 9'hA3, 1'b1, 2'b00, 1'b0);
    check("pin_a3_pe", 1, 32'(pe[1]), 32'd1);
    check("pin_a3_data", 1, 32'(dout_b), 32'hA3);
    send_frame(1, 9'hA3, 1'b0, 2'b00, 1'b0);
    check("pin_a3_pe_ok", 1, 32'(pe[1]), 32'd0);

    // 7 data bits, odd parity, two stop bits, back-to-back
    send_frame(2, 9'h7F, 1'b0, 2'b00, 1'b0);
    send_frame(2, 9'h00, 1'b0, 2'b00, 1'b0);
    check("pin_b2b_data", 2, 32'(dout_c), 32'h00);
    send_frame(2, 9'h15, 1'b0, 2'b01, 1'b0);
    check("pin_first_stop_low_fe", 2, 32'(fe[2]), 32'd1);

    // randomised traffic
    for (int n = 0; n < 16; n++) begin
      inst = $urandom_range(0, 2);
      flip = (cfg_par[inst] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      sl = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (cfg_ns[inst] == 1) sl[1] = 1'b0;
      send_frame(inst, 9'($urandom), flip, sl, 1'b0);
      gap = $urandom_range(0, 2);
      if (gap != 0) drive_seg(inst, 1'b1, gap);
    end

    // reset in the middle of a frame
    send_frame(2, 9'h5A, 1'b0, 2'b00, 1'b0);
    drive_seg(2, 1'b1, 3);
    drive_seg(2, 1'b0, 8);
    drive_seg(2, 1'b1, 8);
    drive_seg(2, 1'b0, 8);
    check("busy_midframe", 2, 32'(busy[2]), 32'd1);
    rst_n[2] = 1'b0;
    last[2] = '0;
    line[2] = 1'b1;
    #1;
    check("midreset_data", 2, 32'(dout_c), 32'd0);
    check("midreset_busy", 2, 32'(busy[2]), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n[2] = 1'b1;
    drive_seg(2, 1'b1, 40);
    check("after_reset_data", 2, 32'(dout_c), 32'd0);
    check("no_pending_frames", 0, 32'(expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
